// File: rtl/l2_cache_test.sv
// l2_cache_test: 8-line fully associative, write-back, write-allocate L2 cache.
// Serves 32-bit L1 words and moves 64-bit lines to and from main memory.
// REPL selects the victim policy: 0 random (LFSR), 1 tree PLRU, 2 true LRU.
// Define L2_DEBUG_EN to trace every lookup and eviction with $display.
module l2_cache_test #(
  parameter int unsigned REPL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stb,
  input  logic             weL1L2,
  input  logic             addrstbL1L2,
  input  logic [31:0]      addrL1L2,
  output logic             stall,
  output logic             weL2MEM,
  output logic             addrstbL2MEM,
  output logic [31:0]      addrL2MEM,
  inout  wire logic [31:0] dataL1L2,
  inout  wire logic [63:0] dataL2MEM
);

  localparam int unsigned NUM_LINES = 8;

  typedef enum logic [2:0] {StIdle, StLookup, StWriteback, StFill, StRespond} state_e;

  state_e      state_q, state_d;
  logic [28:0] req_tag_q;
  logic        req_wsel_q, req_we_q;
  logic [31:0] req_wdata_q;
  logic [2:0]  idx_q;
  logic        sent_q, sent_d;
  logic [7:0]  lfsr_q;
  logic [6:0]  plru_q, plru_d;
  logic [2:0]  age_q [NUM_LINES];
  logic [2:0]  age_d [NUM_LINES];
  logic [31:0] cache_hit_counter, cache_miss_counter;

  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [28:0]          tag_q  [NUM_LINES];
  logic [63:0]          data_q [NUM_LINES];

  logic        hit, has_inv, fill_done, touch_en, l1_drive, mem_drive;
  logic [2:0]  hit_idx, inv_idx, plru_victim, lru_victim, pol_victim, victim, touch_idx;
  logic [63:0] sel_line;
  logic        unused_lsbs;

  assign unused_lsbs = ^addrL1L2[1:0];

  function automatic logic [63:0] merge_word(input logic [63:0] line, input logic wsel,
                                             input logic [31:0] w);
    merge_word = wsel ? {w, line[31:0]} : {line[63:32], w};
  endfunction

  // Tag match and lowest-index invalid line; descending loop lets the lowest index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    has_inv = 1'b0;
    inv_idx = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == req_tag_q) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
      if (!valid_q[i]) begin
        has_inv = 1'b1;
        inv_idx = 3'(i);
      end
    end
  end

  // Policy victims; PLRU node bits point toward the less recently used subtree.
  always_comb begin
    plru_victim[2] = plru_q[0];
    plru_victim[1] = plru_q[3'd1 + {2'b00, plru_victim[2]}];
    plru_victim[0] = plru_q[3'd3 + {1'b0, plru_victim[2:1]}];
    lru_victim     = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (age_q[i] == 3'd7) lru_victim = 3'(i);
    end
    if (REPL == 1)      pol_victim = plru_victim;
    else if (REPL == 2) pol_victim = lru_victim;
    else                pol_victim = lfsr_q[2:0];
    victim = has_inv ? inv_idx : pol_victim;
  end

  assign fill_done = (state_q == StFill) && sent_q && stb;
  assign touch_en  = ((state_q == StLookup) && hit) || fill_done;
  assign touch_idx = (state_q == StLookup) ? hit_idx : idx_q;

  // Replacement-state update on every hit and every fill.
  always_comb begin
    plru_d = plru_q;
    for (int i = 0; i < NUM_LINES; i++) age_d[i] = age_q[i];
    if (touch_en) begin
      plru_d[0]                                   = ~touch_idx[2];
      plru_d[3'd1 + {2'b00, touch_idx[2]}]        = ~touch_idx[1];
      plru_d[3'd3 + {1'b0, touch_idx[2:1]}]       = ~touch_idx[0];
      for (int i = 0; i < NUM_LINES; i++) begin
        if (3'(i) == touch_idx)              age_d[i] = 3'd0;
        else if (age_q[i] < age_q[touch_idx]) age_d[i] = age_q[i] + 3'd1;
      end
    end
  end

  // Bus-facing outputs decoded from the current state.
  always_comb begin
    stall        = 1'b0;
    weL2MEM      = 1'b0;
    addrstbL2MEM = 1'b0;
    addrL2MEM    = '0;
    l1_drive     = 1'b0;
    mem_drive    = 1'b0;
    case (state_q)
      StLookup:    stall = 1'b1;
      StWriteback: begin
        stall        = 1'b1;
        weL2MEM      = 1'b1;
        addrstbL2MEM = !sent_q;
        addrL2MEM    = {tag_q[idx_q], 3'b000};
        mem_drive    = 1'b1;
      end
      StFill: begin
        stall        = 1'b1;
        addrstbL2MEM = !sent_q;
        addrL2MEM    = {req_tag_q, 3'b000};
      end
      StRespond:   l1_drive = !req_we_q;
      default:     ;
    endcase
  end

  // Next-state logic; sent_d marks that this state's memory strobe has gone out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      if (addrstbL1L2) state_d = StLookup;
      StLookup: begin
        if (hit)                                  state_d = StRespond;
        else if (valid_q[victim] && dirty_q[victim]) state_d = StWriteback;
        else                                      state_d = StFill;
      end
      StWriteback: if (sent_q && stb) state_d = StFill;
      StFill:      if (sent_q && stb) state_d = StRespond;
      StRespond:   state_d = StIdle;
      default:     state_d = StIdle;
    endcase
    sent_d = (state_d == state_q) && (sent_q || addrstbL2MEM);
  end

  assign sel_line  = data_q[idx_q];
  assign dataL1L2  = l1_drive ? (req_wsel_q ? sel_line[63:32] : sel_line[31:0]) : 'z;
  assign dataL2MEM = mem_drive ? sel_line : 'z;

  // Control state: FSM, request latch, LFSR, replacement state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= StIdle;
      req_tag_q          <= '0;
      req_wsel_q         <= 1'b0;
      req_we_q           <= 1'b0;
      req_wdata_q        <= '0;
      idx_q              <= '0;
      sent_q             <= 1'b0;
      lfsr_q             <= 8'h01;
      plru_q             <= '0;
      cache_hit_counter  <= '0;
      cache_miss_counter <= '0;
      for (int i = 0; i < NUM_LINES; i++) age_q[i] <= 3'(i);
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      plru_q  <= plru_d;
      for (int i = 0; i < NUM_LINES; i++) age_q[i] <= age_d[i];
      if (state_q == StIdle && addrstbL1L2) begin
        req_tag_q  <= addrL1L2[31:3];
        req_wsel_q <= addrL1L2[2];
        req_we_q   <= weL1L2;
        if (weL1L2) req_wdata_q <= dataL1L2;
      end
      if (state_q == StLookup) begin
        idx_q <= hit ? hit_idx : victim;
        if (hit) cache_hit_counter  <= cache_hit_counter + 32'd1;
        else     cache_miss_counter <= cache_miss_counter + 32'd1;
      end
    end
  end

  // Line storage: write hits merge in LOOKUP, fills land on the memory strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (state_q == StLookup && hit && req_we_q) begin
        data_q[hit_idx]  <= merge_word(data_q[hit_idx], req_wsel_q, req_wdata_q);
        dirty_q[hit_idx] <= 1'b1;
      end
      if (fill_done) begin
        data_q[idx_q]  <= req_we_q ? merge_word(dataL2MEM, req_wsel_q, req_wdata_q) : dataL2MEM;
        tag_q[idx_q]   <= req_tag_q;
        valid_q[idx_q] <= 1'b1;
        dirty_q[idx_q] <= req_we_q;
      end
    end
  end

`ifdef L2_DEBUG_EN
  // Trace each lookup outcome and each eviction of a valid line.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == StLookup) begin
      $display("L2 addr %h %s %s line %0d hits %0d misses %0d",
               {req_tag_q, req_wsel_q, 2'b00}, req_we_q ? "W" : "R", hit ? "HIT" : "MISS",
               hit ? hit_idx : victim, cache_hit_counter, cache_miss_counter);
      if (!hit && valid_q[victim]) begin
        $display("L2 evict tag %h dirty %0b", tag_q[victim], dirty_q[victim]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2_cache_test.sv
// Bench for l2_cache_test: table of L1 requests with expected data, latency and memory
// traffic, a behavioural main memory, and hand-written reset sequences.
module tb_l2_cache_test;

  localparam int MemLat = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_mem;
  } vec_t;

  logic        clk, rst_n, stb, weL1L2, addrstbL1L2;
  logic [31:0] addrL1L2;
  logic        stall, weL2MEM, addrstbL2MEM;
  logic [31:0] addrL2MEM;
  wire  [31:0] dataL1L2;
  wire  [63:0] dataL2MEM;
  logic        l1_oe, mem_oe;
  logic [31:0] l1_data;
  logic [63:0] mem_data;

  assign dataL1L2  = l1_oe ? l1_data : 'z;
  assign dataL2MEM = mem_oe ? mem_data : 'z;

  l2_cache_test #(.REPL(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stb          (stb),
    .weL1L2       (weL1L2),
    .addrstbL1L2  (addrstbL1L2),
    .addrL1L2     (addrL1L2),
    .stall        (stall),
    .weL2MEM      (weL2MEM),
    .addrstbL2MEM (addrstbL2MEM),
    .addrL2MEM    (addrL2MEM),
    .dataL1L2     (dataL1L2),
    .dataL2MEM    (dataL2MEM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int mem_reqs = 0;
  logic [63:0] mem [logic [31:0]];
  logic [31:0] wb_addr_log [$];
  logic [63:0] wb_data_log [$];
  logic [31:0] rd_addr_log [$];
  logic [31:0] exp_q [$];

  function automatic logic [63:0] dflt_line(input logic [31:0] a);
    return {a ^ 32'h5A5A_5A5A, a ^ 32'hA5A5_A5A5};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Main memory: answers each strobe MemLat cycles later with a one-cycle stb.
  initial begin
    logic        mwe, aborted;
    logic [31:0] maddr;
    stb = 1'b0;
    mem_oe = 1'b0;
    mem_data = '0;
    mem[32'h100] = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    forever begin
      if (rst_n && addrstbL2MEM) begin
        mwe = weL2MEM;
        maddr = addrL2MEM;
        mem_reqs++;
        aborted = 1'b0;
        for (int k = 0; k < MemLat; k++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        if (!aborted) begin
          stb = 1'b1;
          if (mwe) begin
            mem[maddr] = dataL2MEM;
            wb_addr_log.push_back(maddr);
            wb_data_log.push_back(dataL2MEM);
          end else begin
            mem_data = mem.exists(maddr) ? mem[maddr] : dflt_line(maddr);
            mem_oe = 1'b1;
            rd_addr_log.push_back(maddr);
          end
          @(negedge clk);
          stb = 1'b0;
          mem_oe = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  // One L1 request; returns cycles from accept to RESPOND, read data and L1 bus enable.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic drv);
    @(negedge clk);
    addrstbL1L2 = 1'b1;
    weL1L2 = we;
    addrL1L2 = a;
    l1_data = wd;
    l1_oe = we;
    @(posedge clk);
    #1;
    addrstbL1L2 = 1'b0;
    weL1L2 = 1'b0;
    l1_oe = 1'b0;
    check("stall_after_accept", 64'(stall), 64'd1);
    lat = 1;
    while (stall && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("respond_reached", 64'(stall), 64'd0);
    rd = dataL1L2;
    drv = dut.l1_drive;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_stall"}, 64'(stall), 64'd0);
    check({tag, "_addrstbL2MEM"}, 64'(addrstbL2MEM), 64'd0);
    check({tag, "_weL2MEM"}, 64'(weL2MEM), 64'd0);
    check({tag, "_addrL2MEM"}, 64'(addrL2MEM), 64'd0);
    check({tag, "_l1_bus_released"}, 64'(dut.l1_drive), 64'd0);
    check({tag, "_mem_bus_released"}, 64'(dut.mem_drive), 64'd0);
    check({tag, "_hit_counter"}, 64'(dut.cache_hit_counter), 64'd0);
    check({tag, "_miss_counter"}, 64'(dut.cache_miss_counter), 64'd0);
    check({tag, "_valid"}, 64'(dut.valid_q), 64'd0);
  endtask

  task automatic do_reset();
    addrstbL1L2 = 1'b0;
    weL1L2 = 1'b0;
    l1_oe = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    reset_checks("after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [13];
    logic [63:0] line;
    logic [31:0] rd, exp;
    logic        drv;
    int          lat;

    vecs[0] = '{1'b0, 32'h100, 32'h0, 32'hCAFEF00D, 5, 1};
    vecs[1] = '{1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 2, 0};
    vecs[2] = '{1'b1, 32'h100, 32'h12345678, 32'h0, 2, 0};
    vecs[3] = '{1'b0, 32'h100, 32'h0, 32'h12345678, 2, 0};
    for (int i = 4; i <= 10; i++) begin
      line = dflt_line(32'h100 * (i - 2));
      vecs[i] = '{1'b0, 32'h100 * (i - 2), 32'h0, line[31:0], 5, 1};
    end
    line = dflt_line(32'h900);
    vecs[11] = '{1'b0, 32'h904, 32'h0, line[63:32], 4 + 2 * MemLat, 2};
    vecs[12] = '{1'b0, 32'h100, 32'h0, 32'h12345678, 5, 1};

    addrstbL1L2 = 1'b0;
    weL1L2 = 1'b0;
    addrL1L2 = '0;
    l1_oe = 1'b0;
    l1_data = '0;
    rst_n = 1'b1;
    #1;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      int m0;
      m0 = mem_reqs;
      exp_q.push_back(vecs[i].exp_rdata);
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, drv);
      exp = exp_q.pop_front();
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d_mem_requests", i), 64'(mem_reqs - m0), 64'(vecs[i].exp_mem));
      check($sformatf("vec%0d_l1_drive", i), 64'(drv), 64'(!vecs[i].we));
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(exp));
      if (i == 0) begin
        check("cold_fill_addr", 64'(rd_addr_log[0]), 64'h100);
        check("cold_miss_counter", 64'(dut.cache_miss_counter), 64'd1);
      end
      if (i == 1) check("first_hit_counter", 64'(dut.cache_hit_counter), 64'd1);
    end

    check("writeback_count", 64'(wb_addr_log.size()), 64'd1);
    if (wb_addr_log.size() > 0) begin
      check("writeback_addr", 64'(wb_addr_log[0]), 64'h100);
      check("writeback_data", wb_data_log[0], 64'hDEADBEEF_12345678);
    end
    check("fill_after_writeback", 64'(rd_addr_log[rd_addr_log.size() - 2]), 64'h900);
    check("final_hit_counter", 64'(dut.cache_hit_counter), 64'd3);
    check("final_miss_counter", 64'(dut.cache_miss_counter), 64'd10);

    // Invalid lines are filled lowest index first.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      line = dflt_line(32'h1000 * i);
      do_req(1'b0, 32'h1000 * i, 32'h0, lat, rd, drv);
      check($sformatf("order%0d_rdata", i), 64'(rd), 64'(line[31:0]));
      check($sformatf("order%0d_line_tag", i), 64'(dut.tag_q[i - 1]), 64'((32'h1000 * i) >> 3));
    end
    check("order_valid_mask", 64'(dut.valid_q), 64'h07);

    // Reset in the middle of a fill abandons the miss.
    @(negedge clk);
    addrstbL1L2 = 1'b1;
    addrL1L2 = 32'h100;
    weL1L2 = 1'b0;
    @(posedge clk);
    #1;
    addrstbL1L2 = 1'b0;
    @(posedge clk);
    #1;
    check("midfill_strobe", 64'(addrstbL2MEM), 64'd1);
    check("midfill_addr", 64'(addrL2MEM), 64'h100);
    rst_n = 1'b0;
    #1;
    check("midfill_rst_stall", 64'(stall), 64'd0);
    check("midfill_rst_addrstb", 64'(addrstbL2MEM), 64'd0);
    check("midfill_rst_valid", 64'(dut.valid_q), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_req(1'b0, 32'h100, 32'h0, lat, rd, drv);
    check("post_reset_latency", 64'(lat), 64'd5);
    check("post_reset_rdata", 64'(rd), 64'h12345678);
    check("post_reset_miss_counter", 64'(dut.cache_miss_counter), 64'd1);
    check("post_reset_hit_counter", 64'(dut.cache_hit_counter), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
